round_robin_arbiter: RTL and testbench
======================================

// Module: round_robin_arbiter
// PURPOSE
//  Shares one resource between N requesters. The grant is held until the owner
//    releases it, abandons it, or exceeds a hold limit.
//  Arbitration uses a priority-encoder sub-module. Two selectable policies:
//    - fixed: highest index wins (4'b1xxx -> id 2'b11);
//    - round-robin: rotating priority.
//  Sits between requester blocks and the shared datapath/bus.
//  gnt_id drives the datapath select mux.
// PARAMETERS
//  N         4   number of requesters (>=2)
//  IDW       2   grant-id width, $clog2(N)
//  MAX_HOLD  8   max consecutive grant cycles before forced release; 0 = no limit
// PORTS
//  clk        in   1     clock, rising edge
//  rst        in   1     reset, asynchronous, active-high
//  req        in   N     request per requester, level; held until granted
//  done       in   1     owner releases resource this cycle (1-cycle pulse)
//  rr_en      in   1     0 = fixed priority, 1 = round-robin
//  gnt        out  N     one-hot grant, registered
//  gnt_id     out  IDW   binary index of current owner, valid when gnt_valid
//  gnt_valid  out  1     =|gnt
//  timeout    out  1     1-cycle pulse: grant revoked by hold limit
// BEHAVIOUR
//  Reset (async, immediate):
//    - gnt=0, gnt_id=0, gnt_valid=0, timeout=0;
//    - state=IDLE, last=0, hold_cnt=0.
//  All outputs are registered. No combinational path from req to gnt.
//  FSM IDLE:
//    - If |req, register the winner into gnt/gnt_id, set hold_cnt=1, go to GRANT.
//    - Latency: req sampled at edge k, gnt visible after edge k+1.
//    - If req==0, stay in IDLE with all outputs 0.
//  FSM GRANT, evaluated in this order each edge:
//    a) done=1 -> release: gnt=0, go to IDLE, last=owner, timeout=0.
//    b) req[owner]=0 (abandon) -> release as in (a).
//    c) MAX_HOLD!=0 && hold_cnt==MAX_HOLD -> release, timeout=1 for one cycle,
//       last=owner.
//    d) else hold the grant, hold_cnt++ (saturating).
//  done and the hold limit in the same cycle: done wins, no timeout pulse.
//  After any release, at least one cycle is spent in IDLE (gnt=0).
//  No back-to-back grants, so the datapath always sees a bubble at handover.
//  done while in IDLE is ignored.
//  Requests that rise or fall in other lanes during GRANT do not disturb the owner.
//  Fixed policy:
//    - Winner = highest set index of req.
//    - last is updated but not used.
//  Round-robin policy:
//    - Search descending from (last-1) mod N, wrapping N-1 -> 0.
//    - The last owner therefore has lowest priority.
//    - With last=0 after reset, the order is 3,2,1,0, identical to fixed.
//    - Implement by rotating req right by last, priority-encoding, then rotating
//      the index back mod N.
//  rr_en is sampled only in IDLE. A change during GRANT applies to the next
//    arbitration.
//  hold_cnt width is $clog2(MAX_HOLD+1). It saturates; it never wraps.
//  Reset mid-grant: gnt drops asynchronously. The requester must re-request.
//  Invariant: gnt is one-hot or zero.
//  Invariant: gnt_id equals the encoded gnt whenever gnt_valid=1.
// STRUCTURE
//  Package arb_pkg:
//    - arb_state_t enum {IDLE, GRANT};
//    - default N and IDW localparams.
//  Sub-module prio_enc_n:
//    - parameterised combinational priority encoder, highest index wins;
//    - outputs idx[IDW-1:0] and any.
//  Top level:
//    - FSM, rotate/unrotate logic, last pointer, hold counter;
//    - output registers.
// TESTING
//  1 Reset: assert rst mid-grant of 4'b0100 -> gnt=0, gnt_valid=0, timeout=0
//    with no clock edge; after release, req=0 -> outputs stay 0.
//  2 Fixed: rr_en=0, req=4'b1011 at edge 0 -> gnt=4'b1000, gnt_id=2'b11 after
//    edge 1; done at edge 3 -> gnt=0 after edge 4; req unchanged -> 4'b1000
//    re-granted after edge 5.
//  3 Round-robin: rr_en=1, req=4'b1111 held, done one cycle after each grant ->
//    gnt_id sequence 3,2,1,0,3 with one idle cycle between grants.
//  4 Timeout: MAX_HOLD=8, req=4'b0100 held, no done -> gnt=4'b0100 for exactly
//    8 cycles, then gnt=0 with timeout=1 for one cycle, re-grant the next cycle.
//  5 Abandon/collision:
//    - owner 2 drops req without done -> release, no timeout;
//    - separately, done coincident with hold_cnt==MAX_HOLD -> release, timeout=0.
//  6 Policy switch: rr_en 0->1 while owner 3 holds grant, req=4'b1001, done ->
//    next grant is id 0 (last=3 -> search 2,1,0,3).

Source files
------------

// File: rtl/arb_pkg.sv
`default_nettype none
// ============================================================================
// Package     : arb_pkg
// Description : Shared types and default sizes for the round-robin arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
package arb_pkg;

  localparam int N_DEFAULT   = 4;
  localparam int IDW_DEFAULT = 2;

  // Two-state arbitration FSM: waiting for requests / resource owned.
  typedef enum logic [0:0] {
    IDLE  = 1'b0,
    GRANT = 1'b1
  } arb_state_t;

endpackage : arb_pkg
`default_nettype wire

// File: rtl/prio_enc_n.sv
`default_nettype none
// ============================================================================
// Module      : prio_enc_n
// Description : Parameterised combinational priority encoder. The highest set
//               index wins; any_o flags that at least one input is set.
// Revision    : 1.0 - initial release
// ============================================================================
module prio_enc_n #(
  parameter int N   = 4,
  parameter int IDW = 2
) (
  input  logic [N-1:0]   req_i,
  output logic [IDW-1:0] idx_o,
  output logic           any_o
);

  // Ascending scan so the last (highest) set bit overwrites lower ones.
  always_comb begin
    idx_o = '0;
    for (int i = 0; i < N; i++) begin
      if (req_i[i]) begin
        idx_o = IDW'(i);
      end
    end
  end

  assign any_o = |req_i;

endmodule : prio_enc_n
`default_nettype wire

// File: rtl/round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : round_robin_arbiter
// Description : Grants one shared resource to one of N requesters. The grant
//               is held until done, abandonment or the hold limit. Fixed
//               (highest index) or round-robin (last owner lowest) policy.
//               Every release passes through one IDLE cycle.
// Revision    : 1.0 - initial release
// ============================================================================
module round_robin_arbiter
  import arb_pkg::*;
#(
  parameter int N        = N_DEFAULT,
  parameter int IDW      = IDW_DEFAULT,
  parameter int MAX_HOLD = 8
) (
  input  logic           clk,
  input  logic           rst,
  input  logic [N-1:0]   req_i,
  input  logic           done_i,
  input  logic           rr_en_i,
  output logic [N-1:0]   gnt_o,
  output logic [IDW-1:0] gnt_id_o,
  output logic           gnt_valid_o,
  output logic           timeout_o
);

  // Counter wide enough to reach MAX_HOLD; one bit when the limit is disabled.
  localparam int HCW = (MAX_HOLD > 0) ? $clog2(MAX_HOLD + 1) : 1;

  localparam logic [HCW-1:0] c_HOLD_MAX = HCW'(MAX_HOLD);
  localparam logic [HCW-1:0] c_HOLD_SAT = {HCW{1'b1}};
  localparam logic [IDW:0]   c_N        = (IDW + 1)'(N);
  localparam logic [N-1:0]   c_ONE      = {{(N - 1){1'b0}}, 1'b1};

  arb_state_t     state_q,    state_d;
  logic [N-1:0]   gnt_q,      gnt_d;
  logic [IDW-1:0] gnt_id_q,   gnt_id_d;
  logic           timeout_q,  timeout_d;
  logic [IDW-1:0] last_q,     last_d;
  logic [HCW-1:0] hold_cnt_q, hold_cnt_d;

  logic [IDW-1:0] w_shift;
  logic [2*N-1:0] w_req_dbl;
  logic [2*N-1:0] w_dbl_shr;
  logic [N-1:0]   w_req_rot;
  logic [IDW-1:0] w_rot_idx;
  logic           w_any;
  logic [IDW:0]   w_sum;
  logic [IDW:0]   w_sum_wrap;
  logic [IDW-1:0] w_win_id;
  logic [N-1:0]   w_win_onehot;
  logic           w_owner_req;

  // Fixed policy is round-robin with a zero rotation, so one encoder serves both.
  assign w_shift = rr_en_i ? last_q : '0;

  // Rotate right by the last owner: rotated bit i is request (i + last) mod N,
  // which puts the last owner at position 0, i.e. lowest priority.
  assign w_req_dbl = {req_i, req_i};
  assign w_dbl_shr = w_req_dbl >> w_shift;
  assign w_req_rot = w_dbl_shr[N-1:0];

  prio_enc_n #(
    .N   (N),
    .IDW (IDW)
  ) u_prio_enc (
    .req_i (w_req_rot),
    .idx_o (w_rot_idx),
    .any_o (w_any)
  );

  // Undo the rotation: winner = (rotated index + last) mod N.
  assign w_sum        = {1'b0, w_rot_idx} + {1'b0, w_shift};
  assign w_sum_wrap   = w_sum - c_N;
  assign w_win_id     = (w_sum >= c_N) ? w_sum_wrap[IDW-1:0] : w_sum[IDW-1:0];
  assign w_win_onehot = c_ONE << w_win_id;

  // Owner still requesting; other lanes are masked out so they cannot disturb it.
  assign w_owner_req = |(req_i & gnt_q);

  // Next-state logic: arbitrate in IDLE, then done > abandon > hold limit in GRANT.
  always_comb begin
    state_d    = state_q;
    gnt_d      = gnt_q;
    gnt_id_d   = gnt_id_q;
    timeout_d  = 1'b0;
    last_d     = last_q;
    hold_cnt_d = hold_cnt_q;
    case (state_q)
      IDLE: begin
        if (w_any) begin
          gnt_d      = w_win_onehot;
          gnt_id_d   = w_win_id;
          hold_cnt_d = HCW'(1);
          state_d    = GRANT;
        end else begin
          gnt_d    = '0;
          gnt_id_d = '0;
        end
      end
      GRANT: begin
        if (done_i || !w_owner_req) begin
          gnt_d      = '0;
          gnt_id_d   = '0;
          last_d     = gnt_id_q;
          hold_cnt_d = '0;
          state_d    = IDLE;
        end else if ((MAX_HOLD != 0) && (hold_cnt_q == c_HOLD_MAX)) begin
          gnt_d      = '0;
          gnt_id_d   = '0;
          last_d     = gnt_id_q;
          hold_cnt_d = '0;
          timeout_d  = 1'b1;
          state_d    = IDLE;
        end else if (hold_cnt_q != c_HOLD_SAT) begin
          hold_cnt_d = hold_cnt_q + HCW'(1);
        end
      end
      default: begin
        gnt_d      = '0;
        gnt_id_d   = '0;
        hold_cnt_d = '0;
        state_d    = IDLE;
      end
    endcase
  end

  // State and output registers; reset clears the grant immediately.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      gnt_q      <= '0;
      gnt_id_q   <= '0;
      timeout_q  <= 1'b0;
      last_q     <= '0;
      hold_cnt_q <= '0;
    end else begin
      state_q    <= state_d;
      gnt_q      <= gnt_d;
      gnt_id_q   <= gnt_id_d;
      timeout_q  <= timeout_d;
      last_q     <= last_d;
      hold_cnt_q <= hold_cnt_d;
    end
  end

  assign gnt_o       = gnt_q;
  assign gnt_id_o    = gnt_id_q;
  assign gnt_valid_o = |gnt_q;
  assign timeout_o   = timeout_q;

endmodule : round_robin_arbiter
`default_nettype wire

// File: tb/tb_round_robin_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_round_robin_arbiter
// Description : Self-checking bench for round_robin_arbiter: directed
//               scenarios plus randomized traffic against a reference model.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_round_robin_arbiter;

  localparam int NREQ     = 4;
  localparam int MAX_HOLD = 8;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] req;
  logic       done;
  logic       rr_en;
  logic [3:0] gnt;
  logic [1:0] gnt_id;
  logic       gnt_valid;
  logic       timeout;

  int checks   = 0;
  int failures = 0;

  round_robin_arbiter #(
    .N        (NREQ),
    .IDW      (2),
    .MAX_HOLD (MAX_HOLD)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .req_i       (req),
    .done_i      (done),
    .rr_en_i     (rr_en),
    .gnt_o       (gnt),
    .gnt_id_o    (gnt_id),
    .gnt_valid_o (gnt_valid),
    .timeout_o   (timeout)
  );

  always #5 clk = ~clk;

  // ---------------- reference model ----------------
  int m_own;   // -1 when nobody owns the resource
  int m_last;
  int m_hold;
  bit m_to;

  // Search descending from (last-1) mod N in round-robin, from N-1 in fixed.
  function automatic int pick(logic [3:0] r, logic rr, int last);
    int start;
    int idx;
    start = rr ? (last + NREQ - 1) % NREQ : NREQ - 1;
    for (int k = 0; k < NREQ; k++) begin
      idx = (start - k + NREQ) % NREQ;
      if (r[idx]) return idx;
    end
    return -1;
  endfunction

  always @(posedge clk or posedge rst) begin
    if (rst) begin
      m_own  <= -1;
      m_last <= 0;
      m_hold <= 0;
      m_to   <= 1'b0;
    end else begin
      m_to <= 1'b0;
      if (m_own < 0) begin
        if (req != 4'b0000) begin
          m_own  <= pick(req, rr_en, m_last);
          m_hold <= 1;
        end
      end else if (done || (((req >> m_own) & 4'b0001) == 4'b0000)) begin
        m_last <= m_own;
        m_own  <= -1;
        m_hold <= 0;
      end else if (m_hold == MAX_HOLD) begin
        m_last <= m_own;
        m_own  <= -1;
        m_hold <= 0;
        m_to   <= 1'b1;
      end else begin
        m_hold <= m_hold + 1;
      end
    end
  end

  function automatic logic [3:0] exp_gnt();
    return (m_own < 0) ? 4'b0000 : (4'b0001 << m_own);
  endfunction

  function automatic logic [1:0] exp_id();
    return (m_own < 0) ? 2'd0 : 2'(m_own);
  endfunction

  // ---------------- helpers ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    req  = 4'b0000;
    done = 1'b0;
    rst  = 1'b1;
    #2;
    rst  = 1'b0;
    tick();
  endtask

  // ---------------- scenarios ----------------
  task automatic test_reset();
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL reset_state: gnt=%b valid=%b to=%b id=%0d want 0000/0/0/0", gnt, gnt_valid, timeout, gnt_id);
    end
    rst = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0000) begin
      failures++;
      $display("FAIL reset_idle_noreq: gnt=%b want 0000", gnt);
    end
    req = 4'b0100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      failures++;
      $display("FAIL reset_pre_grant: gnt=%b id=%0d want 0100/2", gnt, gnt_id);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL reset_async: gnt=%b valid=%b to=%b want 0000/0/0", gnt, gnt_valid, timeout);
    end
    req = 4'b0000;
    tick();
    rst = 1'b0;
    tick();
    tick();
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_after_release: gnt=%b valid=%b want 0000/0", gnt, gnt_valid);
    end
  endtask

  task automatic test_fixed();
    do_reset();
    rr_en = 1'b0;
    req   = 4'b1011;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3 || gnt_valid !== 1'b1) begin
      failures++;
      $display("FAIL fixed_grant: gnt=%b id=%0d want 1000/3", gnt, gnt_id);
    end
    tick();
    tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || gnt_valid !== 1'b0) begin
      failures++;
      $display("FAIL fixed_release: gnt=%b want 0000", gnt);
    end
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      failures++;
      $display("FAIL fixed_regrant: gnt=%b id=%0d want 1000/3", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_round_robin();
    int seq[5] = '{3, 2, 1, 0, 3};
    do_reset();
    rr_en = 1'b1;
    req   = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      tick();
      checks++;
      if (gnt_id !== 2'(seq[i]) || gnt !== (4'b0001 << seq[i])) begin
        failures++;
        $display("FAIL rr_seq[%0d]: gnt=%b id=%0d want id %0d", i, gnt, gnt_id, seq[i]);
      end
      done = 1'b1;
      tick();
      done = 1'b0;
      checks++;
      if (gnt !== 4'b0000) begin
        failures++;
        $display("FAIL rr_bubble[%0d]: gnt=%b want 0000", i, gnt);
      end
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_timeout();
    do_reset();
    rr_en = 1'b0;
    req   = 4'b0100;
    tick();
    for (int i = 0; i < MAX_HOLD; i++) begin
      checks++;
      if (gnt !== 4'b0100 || timeout !== 1'b0) begin
        failures++;
        $display("FAIL timeout_hold[%0d]: gnt=%b to=%b want 0100/0", i, gnt, timeout);
      end
      tick();
    end
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b1) begin
      failures++;
      $display("FAIL timeout_pulse: gnt=%b to=%b want 0000/1", gnt, timeout);
    end
    tick();
    checks++;
    if (gnt !== 4'b0100 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL timeout_regrant: gnt=%b to=%b want 0100/0", gnt, timeout);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_abandon();
    do_reset();
    rr_en = 1'b0;
    req   = 4'b0100;
    tick();
    req = 4'b1100;
    tick();
    checks++;
    if (gnt !== 4'b0100 || gnt_id !== 2'd2) begin
      failures++;
      $display("FAIL abandon_other_lane: gnt=%b id=%0d want 0100/2", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL abandon_release: gnt=%b to=%b want 0000/0", gnt, timeout);
    end
    tick();
    // done in IDLE must be ignored
    done = 1'b1;
    req  = 4'b0010;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 4'b0010) begin
      failures++;
      $display("FAIL done_in_idle: gnt=%b want 0010", gnt);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_collision();
    do_reset();
    rr_en = 1'b0;
    req   = 4'b0100;
    tick();
    repeat (MAX_HOLD - 1) tick();
    done = 1'b1;
    tick();
    done = 1'b0;
    checks++;
    if (gnt !== 4'b0000 || timeout !== 1'b0) begin
      failures++;
      $display("FAIL collision: gnt=%b to=%b want 0000/0", gnt, timeout);
    end
    req = 4'b0000;
    tick();
  endtask

  task automatic test_policy_switch();
    do_reset();
    rr_en = 1'b0;
    req   = 4'b1001;
    tick();
    rr_en = 1'b1;
    tick();
    checks++;
    if (gnt !== 4'b1000 || gnt_id !== 2'd3) begin
      failures++;
      $display("FAIL policy_hold: gnt=%b id=%0d want 1000/3", gnt, gnt_id);
    end
    done = 1'b1;
    tick();
    done = 1'b0;
    tick();
    checks++;
    if (gnt !== 4'b0001 || gnt_id !== 2'd0) begin
      failures++;
      $display("FAIL policy_switch: gnt=%b id=%0d want 0001/0", gnt, gnt_id);
    end
    req = 4'b0000;
    tick();
    tick();
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      if ($urandom_range(0, 5) == 0) req = 4'($urandom);
      done = ($urandom_range(0, 9) == 0);
      if ($urandom_range(0, 7) == 0) rr_en = ~rr_en;
      tick();
      checks++;
      if (gnt !== exp_gnt() || gnt_valid !== (m_own >= 0) || timeout !== m_to) begin
        failures++;
        $display("FAIL rand_out[%0d]: gnt=%b valid=%b to=%b want %b/%b/%b",
                 c, gnt, gnt_valid, timeout, exp_gnt(), (m_own >= 0), m_to);
      end
      checks++;
      if (gnt_id !== exp_id() || !$onehot0(gnt)) begin
        failures++;
        $display("FAIL rand_id[%0d]: id=%0d gnt=%b want id %0d", c, gnt_id, gnt, exp_id());
      end
    end
    done = 1'b0;
  endtask

  initial begin
    rst   = 1'b1;
    req   = 4'b0000;
    done  = 1'b0;
    rr_en = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    test_reset();
    test_fixed();
    test_round_robin();
    test_timeout();
    test_abandon();
    test_collision();
    test_policy_switch();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_round_robin_arbiter
`default_nettype wire
